// File: rtl/reg_port_arbiter.sv
// -----------------------------------------------------------------------------
// reg_port_arbiter
//
// Purpose:
//   The register file has one access slot per clock: either one write or one
//   read. This block shares that slot between the writeback stage (writes)
//   and the decode stage (reads). Writes win by default. A streak counter
//   forces a read grant after STARVE_LIMIT consecutive writes while a read
//   waits. Read data returns through a one-entry valid/ready response stage.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   wr_valid_i/wr_rd_i/wr_data_i  write request (destination, data)
//   wr_ready_o                    write granted this cycle
//   rd_valid_i/rd_rs1_i/rd_rs2_i  read request (two source registers)
//   rd_ready_o                    read granted this cycle
//   resp_valid_o/resp_ready_i     read response handshake
//   resp_data1_o/resp_data2_o     read data (rf_out1/2 while resp_valid_o)
//   rf_reg_write_o                register file: 1 = write, 0 = read
//   rf_rs1_o/rf_rs2_o             register file read addresses
//   rf_rd_o/rf_write_data_o       register file write address and data
//   rf_out1_i/rf_out2_i           register file read data (registered there)
// -----------------------------------------------------------------------------
module reg_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_valid_i,
  input  logic [4:0]  wr_rd_i,
  input  logic [31:0] wr_data_i,
  output logic        wr_ready_o,
  input  logic        rd_valid_i,
  input  logic [4:0]  rd_rs1_i,
  input  logic [4:0]  rd_rs2_i,
  output logic        rd_ready_o,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data1_o,
  output logic [31:0] resp_data2_o,
  output logic        rf_reg_write_o,
  output logic [4:0]  rf_rs1_o,
  output logic [4:0]  rf_rs2_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_write_data_o,
  input  logic [31:0] rf_out1_i,
  input  logic [31:0] rf_out2_i
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic [4:0]       last_rs1_q, last_rs1_d;
  logic [4:0]       last_rs2_q, last_rs2_d;
  logic [4:0]       last_rd_q, last_rd_d;
  logic [31:0]      last_wdata_q, last_wdata_d;

  logic rd_blocked_s;
  logic grant_rd_s;
  logic grant_wr_s;

  // Slot arbitration: a held response blocks reads (rf_out must not move),
  // otherwise writes win unless the streak counter says the read has waited
  // long enough.
  always_comb begin
    rd_blocked_s = (state_q == FULL) & ~resp_ready_i;
    grant_rd_s   = 1'b0;
    grant_wr_s   = 1'b0;
    if (rst_i) begin
      grant_rd_s = 1'b0;
      grant_wr_s = 1'b0;
    end else begin
      grant_rd_s = rd_valid_i & ~rd_blocked_s &
                   (~wr_valid_i | (streak_q == LIMIT));
      grant_wr_s = wr_valid_i & ~grant_rd_s;
    end
  end

  // Streak counter next state: counts writes that overtook a waiting read.
  always_comb begin
    streak_d = streak_q;
    if (grant_rd_s | ~rd_valid_i) begin
      streak_d = '0;
    end else if (grant_wr_s) begin
      streak_d = (streak_q == LIMIT) ? streak_q : streak_q + CNT_W'(1);
    end else begin
      streak_d = streak_q;
    end
  end

  // Remember the last granted addresses so idle cycles keep rf_out stable.
  always_comb begin
    last_rs1_d   = last_rs1_q;
    last_rs2_d   = last_rs2_q;
    last_rd_d    = last_rd_q;
    last_wdata_d = last_wdata_q;
    if (grant_rd_s) begin
      last_rs1_d = rd_rs1_i;
      last_rs2_d = rd_rs2_i;
    end else if (grant_wr_s) begin
      last_rd_d    = wr_rd_i;
      last_wdata_d = wr_data_i;
    end else begin
      last_rs1_d = last_rs1_q;
      last_rs2_d = last_rs2_q;
    end
  end

  // Response FSM next state: FULL holds data until the consumer takes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (grant_rd_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (resp_ready_i & ~grant_rd_s) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register, streak counter and address holding registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      streak_q     <= '0;
      last_rs1_q   <= 5'd0;
      last_rs2_q   <= 5'd0;
      last_rd_q    <= 5'd0;
      last_wdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      last_rs1_q   <= last_rs1_d;
      last_rs2_q   <= last_rs2_d;
      last_rd_q    <= last_rd_d;
      last_wdata_q <= last_wdata_d;
    end
  end

  // Outputs: handshakes, register file drive and response data.
  // Writes to x0 are acknowledged but never reach the register file.
  always_comb begin
    wr_ready_o      = grant_wr_s;
    rd_ready_o      = grant_rd_s;
    resp_valid_o    = (state_q == FULL);
    rf_reg_write_o  = grant_wr_s & (wr_rd_i != 5'd0);
    rf_rs1_o        = grant_rd_s ? rd_rs1_i : last_rs1_q;
    rf_rs2_o        = grant_rd_s ? rd_rs2_i : last_rs2_q;
    rf_rd_o         = grant_wr_s ? wr_rd_i : last_rd_q;
    rf_write_data_o = grant_wr_s ? wr_data_i : last_wdata_q;
    if (state_q == FULL) begin
      resp_data1_o = rf_out1_i;
      resp_data2_o = rf_out2_i;
    end else begin
      resp_data1_o = 32'd0;
      resp_data2_o = 32'd0;
    end
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
module tb_reg_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, rd_valid, resp_ready;
  logic [4:0]  wr_rd, rd_rs1, rd_rs2;
  logic [31:0] wr_data;
  logic        wr_ready, rd_ready, resp_valid, rf_reg_write;
  logic [31:0] resp_data1, resp_data2, rf_write_data;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic [31:0] rf_out1, rf_out2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [32];     // register file model
  logic [31:0] shadow [32];  // expected architectural register contents
  logic [63:0] exp_q [$];    // expected {data1, data2} per granted read

  always #5 clk = ~clk;

  reg_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk_i(clk), .rst_i(rst),
    .wr_valid_i(wr_valid), .wr_rd_i(wr_rd), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_valid_i(rd_valid), .rd_rs1_i(rd_rs1), .rd_rs2_i(rd_rs2), .rd_ready_o(rd_ready),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data1_o(resp_data1), .resp_data2_o(resp_data2),
    .rf_reg_write_o(rf_reg_write), .rf_rs1_o(rf_rs1), .rf_rs2_o(rf_rs2),
    .rf_rd_o(rf_rd), .rf_write_data_o(rf_write_data),
    .rf_out1_i(rf_out1), .rf_out2_i(rf_out2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Register file: writes on posedge, read data registered on read cycles.
  always @(posedge clk) begin
    if (rf_reg_write) begin
      mem[rf_rd] <= rf_write_data;
    end else begin
      rf_out1 <= mem[rf_rs1];
      rf_out2 <= mem[rf_rs2];
    end
  end

  // Scoreboard: push on read grant, pop on response handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check_eq("grant_excl", {31'd0, wr_ready & rd_ready}, 32'd0);
      if (resp_valid && resp_ready) begin
        check_eq("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check_eq("resp_data1", resp_data1, e[63:32]);
          check_eq("resp_data2", resp_data2, e[31:0]);
        end
      end
      if (rd_ready) exp_q.push_back({shadow[rd_rs1], shadow[rd_rs2]});
      if (wr_ready && wr_rd != 5'd0) shadow[wr_rd] = wr_data;
    end
  end

  task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic rv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic rr);
    wr_valid = wv; wr_rd = wrd; wr_data = wd;
    rd_valid = rv; rd_rs1 = rs1; rd_rs2 = rs2; resp_ready = rr;
  endtask

  // Move to the check point of the current cycle (negedge).
  task automatic mid();
    @(negedge clk);
  endtask

  // Advance past the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] w_pat;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'd0;
      shadow[i] = 32'd0;
    end
    rf_out1 = 32'd0; rf_out2 = 32'd0;

    // Reset with requests present: nothing granted.
    rst = 1'b1;
    drive(1'b1, 5'd9, 32'hFFFF_0000, 1'b1, 5'd9, 5'd10, 1'b1);
    for (int c = 0; c < 3; c++) begin
      mid();
      check_eq("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
      check_eq("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
      check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("rst_rf_reg_write", {31'd0, rf_reg_write}, 32'd0);
      if (c > 0) begin
        check_eq("rst_rf_rs1", {27'd0, rf_rs1}, 32'd0);
        check_eq("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
        check_eq("rst_rf_wdata", rf_write_data, 32'd0);
      end
      tick();
    end
    rst = 1'b0;

    // Write x1=5, x2=6, then read them back.
    drive(1'b1, 5'd1, 32'd5, 1'b0, 5'd0, 5'd0, 1'b1);
    mid();
    check_eq("wr1_ready", {31'd0, wr_ready}, 32'd1);
    check_eq("wr1_rf_we", {31'd0, rf_reg_write}, 32'd1);
    check_eq("wr1_rf_rd", {27'd0, rf_rd}, 32'd1);
    tick();
    drive(1'b1, 5'd2, 32'd6, 1'b0, 5'd0, 5'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd2, 1'b1);
    mid();
    check_eq("rd_ready", {31'd0, rd_ready}, 32'd1);
    check_eq("rd_rf_we", {31'd0, rf_reg_write}, 32'd0);
    check_eq("rd_rf_rs1", {27'd0, rf_rs1}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    mid();
    check_eq("rd_resp_valid", {31'd0, resp_valid}, 32'd1);
    check_eq("rd_data1_const", resp_data1, 32'd5);
    check_eq("rd_data2_const", resp_data2, 32'd6);
    tick();
    mid();
    check_eq("rd_resp_drained", {31'd0, resp_valid}, 32'd0);
    tick();

    // Contention: both valid for 8 cycles, expect W W W W R W W W.
    w_pat = 8'b1110_1111; // bit c = 1 means write granted in cycle c
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 5'd7, 32'h100 + 32'(c), 1'b1, 5'd1, 5'd2, 1'b1);
      mid();
      check_eq($sformatf("cont_wr_%0d", c), {31'd0, wr_ready}, {31'd0, w_pat[c]});
      check_eq($sformatf("cont_rd_%0d", c), {31'd0, rd_ready}, {31'd0, ~w_pat[c]});
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    tick();

    // Backpressure: response held for 2 cycles, reads blocked, writes flow.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd2, 1'b1);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd1, 5'd2, 1'b0);
      mid();
      check_eq("bp_rd_ready", {31'd0, rd_ready}, 32'd0);
      check_eq("bp_wr_ready", {31'd0, wr_ready}, 32'd1);
      check_eq("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("bp_data1_held", resp_data1, 32'd5);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd2, 1'b1);
    mid();
    check_eq("bp_release_rd", {31'd0, rd_ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    tick();

    // Write to x0 is acked but never reaches the register file.
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 5'd0, 1'b1);
    mid();
    check_eq("x0_wr_ready", {31'd0, wr_ready}, 32'd1);
    check_eq("x0_rf_we", {31'd0, rf_reg_write}, 32'd0);
    check_eq("x0_rs1_hold", {27'd0, rf_rs1}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd4, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    mid();
    check_eq("x0_data1", resp_data1, 32'd0);
    check_eq("x0_data2", resp_data2, 32'h44);
    tick();

    // RAW: write x3, read it the very next cycle.
    drive(1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 5'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    mid();
    check_eq("raw_data1", resp_data1, 32'h1234);
    tick();

    // Reset with a response pending drops it.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd1, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mid();
    check_eq("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd3, 1'b0);
    mid();
    check_eq("post_rst_rd_ready", {31'd0, rd_ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    tick();
    tick();

    check_eq("sb_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
